mem_wb_stage: RTL and testbench

- MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Captures MEM-stage results and performs load-data extraction and sign/zero extension.
- Drives the write-back bus `RegWrite_wb` / `RegWriteAddr_wb` / `RegWriteData_wb`, which feeds the register file and the ID-stage RAW forwarding selector.
- Also keeps a retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 35 +++
 rtl/mem_wb_stage.sv | 87 ++++++++
 tb/tb_mem_wb_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB stage bus: pipeline control, MEM-stage results and the WB write-back outputs.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              stall;
  logic              flush;
  logic              valid_mem;
  logic              RegWrite_mem;
  logic              MemtoReg_mem;
  logic [2:0]        LoadType_mem;
  logic [4:0]        RegWriteAddr_mem;
  logic [DATA_W-1:0] AluResult_mem;
  logic [DATA_W-1:0] MemReadData_mem;

  logic              RegWrite_wb;
  logic [4:0]        RegWriteAddr_wb;
  logic [DATA_W-1:0] RegWriteData_wb;
  logic              valid_wb;
  logic [CNT_W-1:0]  retired_count;

  // Pipeline side: drives MEM results, observes the write-back bus.
  modport master (
    output stall, flush, valid_mem, RegWrite_mem, MemtoReg_mem, LoadType_mem,
           RegWriteAddr_mem, AluResult_mem, MemReadData_mem,
    input  RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, valid_wb, retired_count
  );

  // Stage side: consumes MEM results, produces the registered write-back bus.
  modport slave (
    input  stall, flush, valid_mem, RegWrite_mem, MemtoReg_mem, LoadType_mem,
           RegWriteAddr_mem, AluResult_mem, MemReadData_mem,
    output RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, valid_wb, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: big-endian load extraction, registered write-back bus and a
// retired-instruction counter. Priority per edge: rst > flush > stall > load.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [2:0] {
    LdW  = 3'b000,
    LdB  = 3'b001,
    LdBu = 3'b010,
    LdH  = 3'b011,
    LdHu = 3'b100
  } load_type_e;

  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;

  logic              r_valid;
  logic              r_we;
  logic [4:0]        r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  // Select the addressed byte/halfword (byte 0 is the MSB) and extend it per load type.
  always_comb begin
    w_off = bus.AluResult_mem[1:0];
    w_byte = 8'h00;
    unique case (w_off)
      2'd0: w_byte = bus.MemReadData_mem[31:24];
      2'd1: w_byte = bus.MemReadData_mem[23:16];
      2'd2: w_byte = bus.MemReadData_mem[15:8];
      2'd3: w_byte = bus.MemReadData_mem[7:0];
    endcase
    w_half = w_off[1] ? bus.MemReadData_mem[15:0] : bus.MemReadData_mem[31:16];
    case (load_type_e'(bus.LoadType_mem))
      LdB:     w_ext = {{24{w_byte[7]}}, w_byte};
      LdBu:    w_ext = {24'h000000, w_byte};
      LdH:     w_ext = {{16{w_half[15]}}, w_half};
      LdHu:    w_ext = {16'h0000, w_half};
      default: w_ext = bus.MemReadData_mem;  // LW and reserved codes
    endcase
  end

  // Write-back data source and enable; a write to $0 is suppressed here so forwarding never sees it.
  always_comb begin
    w_wdata = bus.MemtoReg_mem ? w_ext : bus.AluResult_mem;
    w_we    = bus.RegWrite_mem & bus.valid_mem & (bus.RegWriteAddr_mem != 5'd0);
  end

  // WB register bank and retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= '0;
    end else if (!bus.stall) begin
      r_valid <= bus.valid_mem;
      r_we    <= w_we;
      r_addr  <= bus.RegWriteAddr_mem;
      r_data  <= w_wdata;
      r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, bus.valid_mem};
    end
  end

  assign bus.valid_wb        = r_valid;
  assign bus.RegWrite_wb     = r_we;
  assign bus.RegWriteAddr_wb = r_addr;
  assign bus.RegWriteData_wb = r_data;
  assign bus.retired_count   = r_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, a spec-level model checked every negedge, and
// literal expectations after selected edges. A second DUT with CNT_W=4 exercises counter wrap.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst;

  logic        s_stall, s_flush, s_valid, s_we, s_m2r;
  logic [2:0]  s_lt;
  logic [4:0]  s_addr;
  logic [31:0] s_alu, s_rd;

  mem_wb_stage_if #(.DATA_W(32), .CNT_W(32)) u_if32 ();
  mem_wb_stage_if #(.DATA_W(32), .CNT_W(4))  u_if4 ();

  assign u_if32.stall = s_stall;            assign u_if4.stall = s_stall;
  assign u_if32.flush = s_flush;            assign u_if4.flush = s_flush;
  assign u_if32.valid_mem = s_valid;        assign u_if4.valid_mem = s_valid;
  assign u_if32.RegWrite_mem = s_we;        assign u_if4.RegWrite_mem = s_we;
  assign u_if32.MemtoReg_mem = s_m2r;       assign u_if4.MemtoReg_mem = s_m2r;
  assign u_if32.LoadType_mem = s_lt;        assign u_if4.LoadType_mem = s_lt;
  assign u_if32.RegWriteAddr_mem = s_addr;  assign u_if4.RegWriteAddr_mem = s_addr;
  assign u_if32.AluResult_mem = s_alu;      assign u_if4.AluResult_mem = s_alu;
  assign u_if32.MemReadData_mem = s_rd;     assign u_if4.MemReadData_mem = s_rd;

  mem_wb_stage #(.DATA_W(32), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(u_if32));
  mem_wb_stage #(.DATA_W(32), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level extraction: shift the big-endian lane down, mask, then sign-extend if asked.
  function automatic logic [31:0] m_ext(input logic [2:0] lt, input logic [1:0] off,
                                        input logic [31:0] word);
    int o;
    logic [31:0] v;
    o = int'(off);
    if (lt == 3'd1 || lt == 3'd2) begin
      v = (word >> (8 * (3 - o))) & 32'h0000_00FF;
      if (lt == 3'd1 && v >= 32'h80) v = v - 32'h100;
    end else if (lt == 3'd3 || lt == 3'd4) begin
      v = (word >> (16 * (1 - o / 2))) & 32'h0000_FFFF;
      if (lt == 3'd3 && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Model state: what WB must hold after each edge.
  logic        m_ok = 1'b0;
  logic        m_valid, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int unsigned m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_valid <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_cnt <= 0;
    end else if (s_flush) begin
      m_valid <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_data <= '0;
    end else if (!s_stall) begin
      m_valid <= s_valid;
      m_we    <= s_valid && s_we && s_addr != 5'd0;
      m_addr  <= s_addr;
      m_data  <= s_m2r ? m_ext(s_lt, s_alu[1:0], s_rd) : s_alu;
      m_cnt   <= s_valid ? m_cnt + 1 : m_cnt;
    end
  end

  // Compare both DUTs against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("valid_wb", 32'(u_if32.valid_wb), 32'(m_valid));
      check("RegWrite_wb", 32'(u_if32.RegWrite_wb), 32'(m_we));
      check("RegWriteAddr_wb", 32'(u_if32.RegWriteAddr_wb), 32'(m_addr));
      check("RegWriteData_wb", u_if32.RegWriteData_wb, m_data);
      check("retired_count", u_if32.retired_count, m_cnt);
      check("retired_count4", 32'(u_if4.retired_count), m_cnt % 16);
      check("RegWriteData_wb4", u_if4.RegWriteData_wb, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_lit(input string name, input logic v, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] c);
    check({name, ".valid"}, 32'(u_if32.valid_wb), 32'(v));
    check({name, ".we"}, 32'(u_if32.RegWrite_wb), 32'(we));
    check({name, ".addr"}, 32'(u_if32.RegWriteAddr_wb), 32'(a));
    check({name, ".data"}, u_if32.RegWriteData_wb, d);
    check({name, ".cnt"}, u_if32.retired_count, c);
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [11] = '{
    '{3'd1, 2'd0, 32'hFFFF_FF80}, '{3'd2, 2'd0, 32'h0000_0080},
    '{3'd1, 2'd2, 32'h0000_007F}, '{3'd1, 2'd1, 32'hFFFF_FFF1},
    '{3'd1, 2'd3, 32'h0000_0002}, '{3'd3, 2'd0, 32'hFFFF_80F1},
    '{3'd4, 2'd2, 32'h0000_7F02}, '{3'd4, 2'd1, 32'h0000_80F1},
    '{3'd3, 2'd3, 32'h0000_7F02}, '{3'd0, 2'd3, 32'h80F1_7F02},
    '{3'd7, 2'd1, 32'h80F1_7F02}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_stall = 1'b0; s_flush = 1'b0;
    s_valid = 1'b1; s_we = 1'b1; s_m2r = 1'b0; s_lt = 3'd0; s_addr = 5'd5;
    s_alu = 32'h0000_0000; s_rd = 32'h0000_0000;

    // Reset held two cycles with a valid writing instruction on the inputs.
    tick(); tick();
    wb_lit("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0;
    tick();
    wb_lit("post_reset", 1'b1, 1'b1, 5'd5, 32'h0, 32'd1);

    // ALU path, then the same result aimed at $0.
    s_alu = 32'h1234_5678; s_addr = 5'd8;
    tick();
    wb_lit("alu", 1'b1, 1'b1, 5'd8, 32'h1234_5678, 32'd2);
    s_addr = 5'd0;
    tick();
    wb_lit("alu_r0", 1'b1, 1'b0, 5'd0, 32'h1234_5678, 32'd3);

    // Load extraction: 11 vectors, counter runs 4..14.
    s_m2r = 1'b1; s_addr = 5'd10; s_rd = 32'h80F1_7F02;
    foreach (ld_tab[i]) begin
      s_lt = ld_tab[i].lt;
      s_alu = 32'h0000_1000 | 32'(ld_tab[i].off);
      tick();
      check($sformatf("load%0d", i), u_if32.RegWriteData_wb, ld_tab[i].exp);
    end
    check("load_cnt", u_if32.retired_count, 32'd14);

    // Stall holds addr=3 while inputs move to addr=9.
    s_m2r = 1'b0; s_alu = 32'h0000_0033; s_addr = 5'd3;
    tick();
    wb_lit("pre_stall", 1'b1, 1'b1, 5'd3, 32'h0000_0033, 32'd15);
    s_stall = 1'b1; s_addr = 5'd9; s_alu = 32'h0000_0099;
    for (int k = 0; k < 3; k++) begin
      tick();
      wb_lit($sformatf("stall%0d", k), 1'b1, 1'b1, 5'd3, 32'h0000_0033, 32'd15);
    end

    // Flush beats stall.
    s_flush = 1'b1;
    tick();
    wb_lit("flush_stall", 1'b0, 1'b0, 5'd0, 32'h0, 32'd15);

    // Invalid instruction: no write, counter unchanged, address still captured.
    s_flush = 1'b0; s_stall = 1'b0; s_valid = 1'b0; s_we = 1'b1; s_addr = 5'd7;
    s_alu = 32'h0000_0777;
    tick();
    wb_lit("invalid", 1'b0, 1'b0, 5'd7, 32'h0000_0777, 32'd15);

    // Reset during a stall with a valid instruction discards everything.
    s_valid = 1'b1; s_addr = 5'd12; s_stall = 1'b1; rst = 1'b1;
    tick();
    wb_lit("rst_stall", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    s_stall = 1'b0;
    tick();
    rst = 1'b0;

    // 17 valid instructions: the 4-bit counter wraps to 1.
    for (int k = 0; k < 17; k++) tick();
    check("wrap_cnt4", 32'(u_if4.retired_count), 32'd1);
    check("wrap_cnt32", u_if32.retired_count, 32'd17);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
